// File: rtl/led_code_sched.sv
// led_code_sched
// ---------------------------------------------------------------------------
// Shares one front-panel LED between four status requesters. Every active
// requester gets a blink code, and requester i shows i+1 blinks followed by
// a dark gap. When no requester is active, the LED shows a 1 Hz heartbeat.
// All sequencing advances on a slot tick derived from the system clock.
//
// Parameters
//   P_CLK_FREQ_HZ : system clock frequency in Hz
//   P_TICK_HZ     : slot tick rate in Hz (even, >= 2)
//   P_GAP_SLOTS   : dark slots after each code (>= 1)
//
// Ports
//   clk       : system clock (only clock used)
//   rst       : synchronous reset, active-high
//   req[3:0]  : level status requests, bit 0 has the highest priority
//   led       : LED drive, 1 = lit
//   grant[3:0]: one-hot index of the code being shown, 0 when idle/heartbeat
//   code_done : one-cycle pulse when a code sequence finishes
//
// All outputs are registered, so there is no combinational path from req.
// ---------------------------------------------------------------------------
module led_code_sched #(
  parameter int P_CLK_FREQ_HZ = 100000000,
  parameter int P_TICK_HZ     = 8,
  parameter int P_GAP_SLOTS   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic       led,
  output logic [3:0] grant,
  output logic       code_done
);

  // Terminal counts and counter widths. Each width is the ceiling log2 of
  // the count range, clamped to one bit so degenerate settings still build.
  localparam int N_TICK  = P_CLK_FREQ_HZ / P_TICK_HZ;
  localparam int HB_HALF = P_TICK_HZ / 2;
  localparam int TICK_W  = (N_TICK > 1) ? $clog2(N_TICK) : 1;
  localparam int HB_W    = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;
  localparam int GAP_W   = (P_GAP_SLOTS > 1) ? $clog2(P_GAP_SLOTS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(N_TICK - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HB_HALF - 1);
  localparam logic [HB_W-1:0]   HB_ONE    = HB_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(P_GAP_SLOTS - 1);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLINK_ON,
    S_BLINK_OFF,
    S_GAP
  } state_t;

  state_t             state_q;
  logic [TICK_W-1:0]  tick_cnt_q;
  logic [TICK_W-1:0]  tick_cnt_d;
  logic               tick;
  logic [HB_W-1:0]    hb_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic [1:0]         blinks_left_q;
  logic               led_q;
  logic [3:0]         grant_q;
  logic               code_done_q;

  logic [1:0]         win_idx;
  logic [3:0]         win_onehot;

  // Slot prescaler: tick is high for exactly one clock every N_TICK clocks,
  // in the cycle where the counter sits at its terminal value.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : (tick_cnt_q + TICK_ONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Strict priority arbiter: the lowest set request bit wins. Only sampled
  // by the FSM in IDLE on a tick, so a running code is never preempted.
  always_comb begin
    win_idx    = 2'd0;
    win_onehot = 4'b0000;
    if (req[0]) begin
      win_idx    = 2'd0;
      win_onehot = 4'b0001;
    end else if (req[1]) begin
      win_idx    = 2'd1;
      win_onehot = 4'b0010;
    end else if (req[2]) begin
      win_idx    = 2'd2;
      win_onehot = 4'b0100;
    end else if (req[3]) begin
      win_idx    = 2'd3;
      win_onehot = 4'b1000;
    end
  end

  // Code sequencer. blinks_left holds the number of further blinks after
  // the one currently showing, so winner index w yields w+1 blinks.
  // code_done defaults low every cycle and is only raised on the final gap
  // tick, which makes it a single-cycle pulse aligned with grant clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      hb_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      blinks_left_q <= 2'd0;
      led_q         <= 1'b0;
      grant_q       <= 4'b0000;
      code_done_q   <= 1'b0;
    end else begin
      code_done_q <= 1'b0;
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            if (req != 4'b0000) begin
              grant_q       <= win_onehot;
              blinks_left_q <= win_idx;
              led_q         <= 1'b1;
              state_q       <= S_BLINK_ON;
            end else if (hb_cnt_q == HB_LAST) begin
              led_q    <= ~led_q;
              hb_cnt_q <= '0;
            end else begin
              hb_cnt_q <= hb_cnt_q + HB_ONE;
            end
          end
          S_BLINK_ON: begin
            led_q   <= 1'b0;
            state_q <= S_BLINK_OFF;
          end
          S_BLINK_OFF: begin
            if (blinks_left_q == 2'd0) begin
              gap_cnt_q <= '0;
              state_q   <= S_GAP;
            end else begin
              blinks_left_q <= blinks_left_q - 2'd1;
              led_q         <= 1'b1;
              state_q       <= S_BLINK_ON;
            end
          end
          S_GAP: begin
            led_q <= 1'b0;
            if (gap_cnt_q == GAP_LAST) begin
              code_done_q <= 1'b1;
              grant_q     <= 4'b0000;
              hb_cnt_q    <= '0;
              state_q     <= S_IDLE;
            end else begin
              gap_cnt_q <= gap_cnt_q + GAP_ONE;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign led       = led_q;
  assign grant     = grant_q;
  assign code_done = code_done_q;

endmodule

// File: tb/tb_led_code_sched.sv
// tb_led_code_sched
// ---------------------------------------------------------------------------
// Self-checking bench for led_code_sched with N_TICK = 10 (80 Hz clock,
// 8 Hz slot tick, 4 gap slots). A slot-level reference model predicts the
// outputs every cycle; a table of directed phases checks hand-derived
// values at phase ends; a few sequences cover priority, non-preemption and
// request drop; a randomized phase closes the run.
// ---------------------------------------------------------------------------
module tb_led_code_sched;

  localparam int CLK_HZ   = 80;
  localparam int TICK_HZ  = 8;
  localparam int GAP      = 4;
  localparam int NTICK    = CLK_HZ / TICK_HZ;
  localparam int HB_HALF  = TICK_HZ / 2;
  localparam int WAIT_MAX = 400;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       led;
  logic [3:0] grant;
  logic       code_done;

  int vectors;
  int miscompares;

  // Reference model state, expressed in slots rather than FSM states.
  int         mTick;
  int         mHb;
  bit         mBusy;
  int         mSlot;
  int         mLen;
  int         mBlinkSlots;
  logic       mLed;
  logic [3:0] mGrant;
  logic       mDone;

  led_code_sched #(
    .P_CLK_FREQ_HZ(CLK_HZ),
    .P_TICK_HZ    (TICK_HZ),
    .P_GAP_SLOTS  (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .led      (led),
    .grant    (grant),
    .code_done(code_done)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: every check steps the vector count and, on a
  // difference, the miscompare count.
  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance the reference model by one clock edge using the inputs the DUT
  // sampled. A code of winner w occupies 2(w+1) blink slots (lit on even
  // slot numbers) plus GAP dark slots, then returns to the heartbeat.
  task automatic modelUpdate(input logic r, input logic [3:0] q);
    bit isTick;
    int w;
    if (r) begin
      mTick = 0; mHb = 0; mBusy = 0; mSlot = 0; mLen = 0; mBlinkSlots = 0;
      mLed = 1'b0; mGrant = 4'b0; mDone = 1'b0;
    end else begin
      mDone  = 1'b0;
      isTick = (mTick == NTICK - 1);
      mTick  = isTick ? 0 : mTick + 1;
      if (isTick) begin
        if (!mBusy) begin
          if (q != 4'b0) begin
            w = 0;
            while (!q[w]) w++;
            mBusy       = 1;
            mSlot       = 0;
            mBlinkSlots = 2 * (w + 1);
            mLen        = mBlinkSlots + GAP;
            mLed        = 1'b1;
            mGrant      = 4'b1 << w;
          end else if (mHb == HB_HALF - 1) begin
            mLed = ~mLed;
            mHb  = 0;
          end else begin
            mHb++;
          end
        end else begin
          mSlot++;
          if (mSlot == mLen) begin
            mBusy  = 0;
            mGrant = 4'b0;
            mLed   = 1'b0;
            mDone  = 1'b1;
            mHb    = 0;
          end else begin
            mLed = (mSlot < mBlinkSlots) && (mSlot % 2 == 0);
          end
        end
      end
    end
  endtask

  task automatic checkOutput();
    compare("modelLed", {31'b0, led}, {31'b0, mLed});
    compare("modelGrant", {28'b0, grant}, {28'b0, mGrant});
    compare("modelDone", {31'b0, code_done}, {31'b0, mDone});
  endtask

  // One clock: drive on the falling edge, update the model at the rising
  // edge, and sample the DUT shortly after it.
  task automatic applyStimulus(input logic r, input logic [3:0] q);
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    modelUpdate(r, q);
    #1;
    checkOutput();
  endtask

  // Wait (bounded) for a code to start, check its grant, then count LED
  // blinks until code_done. After switchAfter cycles of the code the held
  // request changes to reqSwitch, to exercise non-preemption.
  task automatic runCode(input logic [3:0] reqHold, input logic [3:0] expGrant,
                         input int expBlinks, input int switchAfter,
                         input logic [3:0] reqSwitch, input string name);
    int   n;
    int   rises;
    logic prevLed;
    logic [3:0] q;
    n = 0;
    while (grant == 4'b0 && n < WAIT_MAX) begin
      applyStimulus(1'b0, reqHold);
      n++;
    end
    compare({name, "Started"}, {31'b0, (grant != 4'b0)}, 32'd1);
    if (grant == 4'b0) return;
    compare({name, "Grant"}, {28'b0, grant}, {28'b0, expGrant});
    rises   = led ? 1 : 0;
    prevLed = led;
    n       = 0;
    q       = reqHold;
    while (!code_done && n < WAIT_MAX) begin
      if (n == switchAfter) q = reqSwitch;
      applyStimulus(1'b0, q);
      if (led && !prevLed) rises++;
      prevLed = led;
      n++;
    end
    compare({name, "Done"}, {31'b0, code_done}, 32'd1);
    compare({name, "Blinks"}, rises, expBlinks);
  endtask

  typedef struct {
    logic       rstVal;
    logic [3:0] reqVal;
    int         steps;
    logic       expLed;
    logic [3:0] expGrant;
    logic       expDone;
    string      name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    req         = 4'b0;
    mTick = 0; mHb = 0; mBusy = 0; mSlot = 0; mLen = 0; mBlinkSlots = 0;
    mLed = 1'b0; mGrant = 4'b0; mDone = 1'b0;

    // Directed phases: heartbeat, one full 3-blink code and its repeat,
    // then a reset landing in BLINK_ON and the first tick after release.
    tbl.push_back('{1'b1, 4'b0000,  1, 1'b0, 4'b0000, 1'b0, "hbReset"});
    tbl.push_back('{1'b0, 4'b0000, 39, 1'b0, 4'b0000, 1'b0, "hbDarkBeforeTick4"});
    tbl.push_back('{1'b0, 4'b0000,  1, 1'b1, 4'b0000, 1'b0, "hbFirstRise"});
    tbl.push_back('{1'b0, 4'b0000, 39, 1'b1, 4'b0000, 1'b0, "hbHoldOn"});
    tbl.push_back('{1'b0, 4'b0000,  1, 1'b0, 4'b0000, 1'b0, "hbFirstFall"});
    tbl.push_back('{1'b1, 4'b0000,  1, 1'b0, 4'b0000, 1'b0, "codeReset"});
    tbl.push_back('{1'b0, 4'b0100,  9, 1'b0, 4'b0000, 1'b0, "codeWaitTick"});
    tbl.push_back('{1'b0, 4'b0100,  1, 1'b1, 4'b0100, 1'b0, "codeGrant"});
    tbl.push_back('{1'b0, 4'b0100, 10, 1'b0, 4'b0100, 1'b0, "codeSlot1Dark"});
    tbl.push_back('{1'b0, 4'b0100, 10, 1'b1, 4'b0100, 1'b0, "codeBlink2"});
    tbl.push_back('{1'b0, 4'b0100, 10, 1'b0, 4'b0100, 1'b0, "codeSlot3Dark"});
    tbl.push_back('{1'b0, 4'b0100, 10, 1'b1, 4'b0100, 1'b0, "codeBlink3"});
    tbl.push_back('{1'b0, 4'b0100, 10, 1'b0, 4'b0100, 1'b0, "codeSlot5Dark"});
    tbl.push_back('{1'b0, 4'b0100, 10, 1'b0, 4'b0100, 1'b0, "codeGapStart"});
    tbl.push_back('{1'b0, 4'b0100, 39, 1'b0, 4'b0100, 1'b0, "codeGapEnd"});
    tbl.push_back('{1'b0, 4'b0100,  1, 1'b0, 4'b0000, 1'b1, "codeDone"});
    tbl.push_back('{1'b0, 4'b0100,  1, 1'b0, 4'b0000, 1'b0, "codeDoneOnce"});
    tbl.push_back('{1'b0, 4'b0100,  9, 1'b1, 4'b0100, 1'b0, "codeRepeat"});
    tbl.push_back('{1'b0, 4'b0100,  5, 1'b1, 4'b0100, 1'b0, "midBlinkOn"});
    tbl.push_back('{1'b1, 4'b0100,  1, 1'b0, 4'b0000, 1'b0, "midReset"});
    tbl.push_back('{1'b0, 4'b0100,  9, 1'b0, 4'b0000, 1'b0, "midWaitTick"});
    tbl.push_back('{1'b0, 4'b0100,  1, 1'b1, 4'b0100, 1'b0, "midFirstTick"});

    foreach (tbl[i]) begin
      for (int s = 0; s < tbl[i].steps; s++) applyStimulus(tbl[i].rstVal, tbl[i].reqVal);
      compare({tbl[i].name, "Led"}, {31'b0, led}, {31'b0, tbl[i].expLed});
      compare({tbl[i].name, "Grant"}, {28'b0, grant}, {28'b0, tbl[i].expGrant});
      compare({tbl[i].name, "Done"}, {31'b0, code_done}, {31'b0, tbl[i].expDone});
    end

    // Priority: req[1] beats req[3], and keeps winning while held.
    applyStimulus(1'b1, 4'b0000);
    runCode(4'b1010, 4'b0010, 2, -1, 4'b1010, "prio1");
    runCode(4'b1010, 4'b0010, 2, -1, 4'b1010, "prio2");

    // Non-preemption: req[0] arrives during the 2nd blink of the req[3] code.
    applyStimulus(1'b1, 4'b0000);
    runCode(4'b1000, 4'b1000, 4, 20, 4'b1001, "nopre");
    runCode(4'b1001, 4'b0001, 1, -1, 4'b1001, "nopreNext");

    // Request drop: a one-cycle request aligned with the first tick.
    applyStimulus(1'b1, 4'b0000);
    for (int s = 0; s < NTICK - 1; s++) applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b0100);
    runCode(4'b0000, 4'b0100, 3, -1, 4'b0000, "drop");
    compare("dropHbLed", {31'b0, led}, 32'd0);
    for (int s = 0; s < 100; s++) applyStimulus(1'b0, 4'b0000);

    // Randomized phase against the reference model.
    applyStimulus(1'b1, 4'b0000);
    for (int k = 0; k < 250; k++) begin
      logic [3:0] q;
      int         hold;
      logic       r;
      q    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) q = 4'b0000;
      hold = $urandom_range(1, 50);
      r    = ($urandom_range(0, 39) == 0);
      for (int s = 0; s < hold; s++) applyStimulus((s == 0) ? r : 1'b0, q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
